conv_row_accumulator: RTL and testbench

- Downstream consumer of the 13-bit row-enable mask produced by the convolution row selector.
- Takes the 13 signed row partial sums from the row convolver bank and adds only the rows enabled by the mask.
- Uses a 5-stage pipelined adder tree with valid/ready handshake; the result goes to the activation/output buffer stage.

---
 rtl/conv_row_accumulator_pkg.sv | 23 ++
 rtl/conv_row_accumulator_if.sv | 42 ++++
 rtl/conv_row_accumulator_add_stage.sv | 61 ++++++
 rtl/conv_row_accumulator.sv | 154 +++++++++++++++
 tb/tb_conv_row_accumulator.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_row_accumulator_pkg.sv
// Shared definitions for the convolution row datapath: row count, guard
// bits for accumulation, default partial-sum width and the packed-row
// slice convention used by the row selector, convolver bank and accumulator.
package conv_row_accumulator_pkg;

    localparam int NUM_CONV_ROWS  = 13;
    localparam int ACC_GUARD_BITS = 4;
    localparam int PSUM_WIDTH_DEF = 20;

    // One enable bit per convolution row, bit r enables row r.
    typedef logic [NUM_CONV_ROWS-1:0] row_mask_t;

    // Row r of a packed partial-sum bus starts at bit r*width.
    function automatic int row_lsb(input int row, input int width);
        return row * width;
    endfunction

    // Number of outputs of a pairwise reduction of n values (odd one passes).
    function automatic int half_up(input int n);
        return (n + 32'sd1) / 32'sd2;
    endfunction

endpackage

// File: rtl/conv_row_accumulator_if.sv
// Handshake/data bundle between the row convolver bank, the accumulator and
// the activation/output buffer. The slave modport is the accumulator's view.
interface conv_row_accumulator_if
    import conv_row_accumulator_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF
) ();

    localparam int OUT_WIDTH = PSUM_WIDTH + ACC_GUARD_BITS;

    logic [NUM_CONV_ROWS*PSUM_WIDTH-1:0] CONV_ACC_Psum;
    row_mask_t                           CONV_ACC_Sel;
    logic                                CONV_ACC_InValid;
    logic                                CONV_ACC_InReady;
    logic [OUT_WIDTH-1:0]                CONV_ACC_Sum;
    logic                                CONV_ACC_OutValid;
    logic                                CONV_ACC_OutReady;
    logic                                CONV_ACC_MaskErr;

    modport master (
        output CONV_ACC_Psum,
        output CONV_ACC_Sel,
        output CONV_ACC_InValid,
        input  CONV_ACC_InReady,
        input  CONV_ACC_Sum,
        input  CONV_ACC_OutValid,
        output CONV_ACC_OutReady,
        input  CONV_ACC_MaskErr
    );

    modport slave (
        input  CONV_ACC_Psum,
        input  CONV_ACC_Sel,
        input  CONV_ACC_InValid,
        output CONV_ACC_InReady,
        output CONV_ACC_Sum,
        output CONV_ACC_OutValid,
        input  CONV_ACC_OutReady,
        output CONV_ACC_MaskErr
    );

endinterface

// File: rtl/conv_row_accumulator_add_stage.sv
// conv_acc_add_stage: one registered level of the accumulation adder tree.
// Reduces N_IN signed values to ceil(N_IN/2) by adding neighbouring pairs;
// an odd last element passes through unchanged. Holds data and valid when
// i_en is low. With RELU set, negative results are loaded as zero.
module conv_acc_add_stage
    import conv_row_accumulator_pkg::*;
#(
    parameter int  N_IN  = 13,
    parameter int  W     = 24,
    parameter bit  RELU  = 1'b0,
    localparam int N_OUT = half_up(N_IN)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [N_IN-1:0][W-1:0]  i_data,
    output logic                  o_valid,
    output logic [N_OUT-1:0][W-1:0] o_data
);

    logic [N_OUT-1:0][W-1:0] w_pair;
    logic [N_OUT-1:0][W-1:0] w_next;
    logic [N_OUT-1:0][W-1:0] r_data;
    logic                    r_valid;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if ((2 * j + 1) < N_IN) begin : g_add
            assign w_pair[j] = i_data[2*j] + i_data[2*j+1];
        end else begin : g_pass
            assign w_pair[j] = i_data[2*j];
        end
    end

    // Optional clamp of negative results before they are registered.
    always_comb begin
        w_next = w_pair;
        for (int j = 0; j < N_OUT; j++) begin
            if (RELU && w_pair[j][W-1]) begin
                w_next[j] = '0;
            end else begin
                w_next[j] = w_pair[j];
            end
        end
    end

    // Stage register: load on enable, otherwise hold data and valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_next;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/conv_row_accumulator.sv
// conv_row_accumulator: adds the row partial sums enabled by the row-select
// mask through a 5-stage pipelined adder tree (S1 gating register, then four
// pairwise reducers 13->7->4->2->1). The whole pipe advances together when
// the output is empty or being consumed; bubbles are carried, not squeezed.
// Accepting an all-zero mask still produces a (zero) result and sets a
// sticky mask-error flag.
// Build option: define CONV_ACC_RELU_EN to clamp negative results to zero
// in the output stage (latency is unchanged).
module conv_row_accumulator
    import conv_row_accumulator_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF
) (
    input  logic                         CONV_ACC_CLOCK_50,
    input  logic                         CONV_ACC_RESET_InHigh,
    conv_row_accumulator_if.slave        acc_bus
);

    localparam int OUT_WIDTH = PSUM_WIDTH + ACC_GUARD_BITS;
    localparam int N_S2      = half_up(NUM_CONV_ROWS);
    localparam int N_S3      = half_up(N_S2);
    localparam int N_S4      = half_up(N_S3);
    localparam int N_S5      = half_up(N_S4);

`ifdef CONV_ACC_RELU_EN
    localparam bit RELU_AT_OUTPUT = 1'b1;
`else
    localparam bit RELU_AT_OUTPUT = 1'b0;
`endif

    logic                                      w_en;
    logic                                      w_accept;
    logic                                      w_sel_zero;
    logic [NUM_CONV_ROWS-1:0][OUT_WIDTH-1:0]   w_s1_gated;
    logic [NUM_CONV_ROWS-1:0][OUT_WIDTH-1:0]   r_s1_data;
    logic                                      r_s1_valid;
    logic [N_S2-1:0][OUT_WIDTH-1:0]            w_s2_data;
    logic                                      w_s2_valid;
    logic [N_S3-1:0][OUT_WIDTH-1:0]            w_s3_data;
    logic                                      w_s3_valid;
    logic [N_S4-1:0][OUT_WIDTH-1:0]            w_s4_data;
    logic                                      w_s4_valid;
    logic [N_S5-1:0][OUT_WIDTH-1:0]            w_s5_data;
    logic                                      w_s5_valid;
    logic                                      r_mask_err;

    // Global pipe enable and input handshake; InReady follows OutReady
    // combinationally so a full pipe can accept while it drains.
    always_comb begin
        w_en       = ~w_s5_valid | acc_bus.CONV_ACC_OutReady;
        w_accept   = w_en & acc_bus.CONV_ACC_InValid;
        w_sel_zero = (acc_bus.CONV_ACC_Sel == {NUM_CONV_ROWS{1'b0}});
    end

    // Mask each row and sign-extend it to the accumulator width.
    always_comb begin
        w_s1_gated = '0;
        for (int r = 0; r < NUM_CONV_ROWS; r++) begin
            if (acc_bus.CONV_ACC_Sel[r]) begin
                w_s1_gated[r] = OUT_WIDTH'(signed'(
                    acc_bus.CONV_ACC_Psum[row_lsb(r, PSUM_WIDTH) +: PSUM_WIDTH]));
            end else begin
                w_s1_gated[r] = '0;
            end
        end
    end

    // S1: capture the gated rows on acceptance; an empty slot loads zeros.
    always_ff @(posedge CONV_ACC_CLOCK_50) begin
        if (CONV_ACC_RESET_InHigh) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_en) begin
            r_s1_valid <= acc_bus.CONV_ACC_InValid;
            if (acc_bus.CONV_ACC_InValid) begin
                r_s1_data <= w_s1_gated;
            end else begin
                r_s1_data <= '0;
            end
        end
    end

    // Sticky flag: set when a transaction with an empty mask is accepted.
    always_ff @(posedge CONV_ACC_CLOCK_50) begin
        if (CONV_ACC_RESET_InHigh) begin
            r_mask_err <= 1'b0;
        end else if (w_accept && w_sel_zero) begin
            r_mask_err <= 1'b1;
        end
    end

    conv_acc_add_stage #(
        .N_IN (NUM_CONV_ROWS),
        .W    (OUT_WIDTH),
        .RELU (1'b0)
    ) u_s2 (
        .i_clk   (CONV_ACC_CLOCK_50),
        .i_rst   (CONV_ACC_RESET_InHigh),
        .i_en    (w_en),
        .i_valid (r_s1_valid),
        .i_data  (r_s1_data),
        .o_valid (w_s2_valid),
        .o_data  (w_s2_data)
    );

    conv_acc_add_stage #(
        .N_IN (N_S2),
        .W    (OUT_WIDTH),
        .RELU (1'b0)
    ) u_s3 (
        .i_clk   (CONV_ACC_CLOCK_50),
        .i_rst   (CONV_ACC_RESET_InHigh),
        .i_en    (w_en),
        .i_valid (w_s2_valid),
        .i_data  (w_s2_data),
        .o_valid (w_s3_valid),
        .o_data  (w_s3_data)
    );

    conv_acc_add_stage #(
        .N_IN (N_S3),
        .W    (OUT_WIDTH),
        .RELU (1'b0)
    ) u_s4 (
        .i_clk   (CONV_ACC_CLOCK_50),
        .i_rst   (CONV_ACC_RESET_InHigh),
        .i_en    (w_en),
        .i_valid (w_s3_valid),
        .i_data  (w_s3_data),
        .o_valid (w_s4_valid),
        .o_data  (w_s4_data)
    );

    // S5 doubles as the output register; the optional clamp lives here only.
    conv_acc_add_stage #(
        .N_IN (N_S4),
        .W    (OUT_WIDTH),
        .RELU (RELU_AT_OUTPUT)
    ) u_s5 (
        .i_clk   (CONV_ACC_CLOCK_50),
        .i_rst   (CONV_ACC_RESET_InHigh),
        .i_en    (w_en),
        .i_valid (w_s4_valid),
        .i_data  (w_s4_data),
        .o_valid (w_s5_valid),
        .o_data  (w_s5_data)
    );

    assign acc_bus.CONV_ACC_InReady  = w_en;
    assign acc_bus.CONV_ACC_Sum      = w_s5_data[0];
    assign acc_bus.CONV_ACC_OutValid = w_s5_valid;
    assign acc_bus.CONV_ACC_MaskErr  = r_mask_err;

endmodule

// File: tb/tb_conv_row_accumulator.sv
// Bench for conv_row_accumulator: directed table of vectors with exact
// latency checks, streaming with backpressure, randomized traffic checked
// by a queue-based reference model, and mid-operation reset.
// Honours CONV_ACC_RELU_EN in its reference model.
module tb_conv_row_accumulator;
    import conv_row_accumulator_pkg::*;

    localparam int PW = 20;
    localparam int NR = 13;

    typedef struct {
        logic [NR*PW-1:0] psum;
        logic [NR-1:0]    sel;
        longint           exp_sum;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;

    conv_row_accumulator_if #(.PSUM_WIDTH(PW)) acc_bus ();

    conv_row_accumulator #(.PSUM_WIDTH(PW)) dut (
        .CONV_ACC_CLOCK_50     (clk),
        .CONV_ACC_RESET_InHigh (rst),
        .acc_bus               (acc_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain sum of enabled rows, clamped when the ReLU build is on.
    function automatic longint model(input logic [NR*PW-1:0] p, input logic [NR-1:0] s);
        longint acc = 0;
        for (int r = 0; r < NR; r++) begin
            if (s[r]) acc += longint'(signed'(p[r*PW +: PW]));
        end
`ifdef CONV_ACC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    function automatic longint relu(input longint v);
`ifdef CONV_ACC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [NR*PW-1:0] fill_all(input int v);
        logic [NR*PW-1:0] p;
        for (int r = 0; r < NR; r++) p[r*PW +: PW] = PW'(v);
        return p;
    endfunction

    function automatic logic [NR*PW-1:0] fill_ramp();
        logic [NR*PW-1:0] p;
        for (int r = 0; r < NR; r++) p[r*PW +: PW] = PW'(r - 6);
        return p;
    endfunction

    function automatic logic [NR*PW-1:0] rand_psum();
        logic [NR*PW-1:0] p;
        for (int r = 0; r < NR; r++) begin
            case ($urandom_range(0, 5))
                0:       p[r*PW +: PW] = 20'h80000;
                1:       p[r*PW +: PW] = 20'h7FFFF;
                default: p[r*PW +: PW] = PW'($urandom);
            endcase
        end
        return p;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    longint exp_q[$];
    logic   m_err     = 1'b0;
    logic   have_hold = 1'b0;
    longint hold_sum  = 0;
    longint popped;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_err     = 1'b0;
            have_hold = 1'b0;
        end else begin
            check("mask_err", longint'(acc_bus.CONV_ACC_MaskErr), longint'(m_err));
            if (have_hold && acc_bus.CONV_ACC_OutValid)
                check("hold_sum", longint'($signed(acc_bus.CONV_ACC_Sum)), hold_sum);
            if (acc_bus.CONV_ACC_OutValid && !acc_bus.CONV_ACC_OutReady)
                check("in_ready_stall", longint'(acc_bus.CONV_ACC_InReady), 0);
            if (acc_bus.CONV_ACC_OutValid && acc_bus.CONV_ACC_OutReady) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got sum %0d, expected no output (t=%0t)",
                             $signed(acc_bus.CONV_ACC_Sum), $time);
                end else begin
                    popped = exp_q.pop_front();
                    check("sum_stream", longint'($signed(acc_bus.CONV_ACC_Sum)), popped);
                    n_out++;
                end
            end
            if (acc_bus.CONV_ACC_InValid && acc_bus.CONV_ACC_InReady) begin
                exp_q.push_back(model(acc_bus.CONV_ACC_Psum, acc_bus.CONV_ACC_Sel));
                if (acc_bus.CONV_ACC_Sel == 13'h0000) m_err = 1'b1;
            end
            have_hold = acc_bus.CONV_ACC_OutValid && !acc_bus.CONV_ACC_OutReady;
            hold_sum  = longint'($signed(acc_bus.CONV_ACC_Sum));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        acc_bus.CONV_ACC_InValid  = 1'b0;
        acc_bus.CONV_ACC_OutReady = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !acc_bus.CONV_ACC_OutValid) done = 1'b1;
        end
        check("drain_done", longint'(done), 1);
        tick();
    endtask

    bit seen_zero = 1'b0;

    // Apply one vector to an empty pipe and check exact latency and result.
    task automatic run_vec(input vec_t v);
        acc_bus.CONV_ACC_OutReady = 1'b1;
        acc_bus.CONV_ACC_InValid  = 1'b1;
        acc_bus.CONV_ACC_Psum     = v.psum;
        acc_bus.CONV_ACC_Sel      = v.sel;
        @(negedge clk);
        check("vec_in_ready", longint'(acc_bus.CONV_ACC_InReady), 1);
        tick();
        if (v.sel == 13'h0000) seen_zero = 1'b1;
        acc_bus.CONV_ACC_InValid = 1'b0;
        acc_bus.CONV_ACC_Sel     = ~v.sel;
        acc_bus.CONV_ACC_Psum    = rand_psum();
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("vec_latency_valid", longint'(acc_bus.CONV_ACC_OutValid), (c == 4) ? 1 : 0);
            if (c == 4) check("vec_sum", longint'($signed(acc_bus.CONV_ACC_Sum)), v.exp_sum);
        end
        check("vec_mask_err", longint'(acc_bus.CONV_ACC_MaskErr), longint'(seen_zero));
    endtask

    vec_t vecs[7];
    bit   rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int acc_cnt;
        int cyc;
        int out0;

        vecs[0] = '{fill_all(1000),    13'h1FFF, 13000};
        vecs[1] = '{fill_ramp(),       13'h001F, relu(-20)};
        vecs[2] = '{fill_ramp(),       13'h1FFF, 0};
        vecs[3] = '{fill_all(-524288), 13'h1FFF, relu(-6815744)};
        vecs[4] = '{fill_all(524287),  13'h1FFF, 6815731};
        vecs[5] = '{fill_ramp(),       13'h1000, 6};
        vecs[6] = '{fill_all(1000),    13'h0000, 0};

        // Reset with a valid input held at the port.
        rst = 1'b1;
        acc_bus.CONV_ACC_InValid  = 1'b1;
        acc_bus.CONV_ACC_OutReady = 1'b1;
        acc_bus.CONV_ACC_Psum     = rand_psum();
        acc_bus.CONV_ACC_Sel      = 13'h1FFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", longint'(acc_bus.CONV_ACC_OutValid), 0);
            check("rst_sum", longint'($signed(acc_bus.CONV_ACC_Sum)), 0);
            check("rst_mask_err", longint'(acc_bus.CONV_ACC_MaskErr), 0);
        end
        rst = 1'b0;
        acc_bus.CONV_ACC_InValid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", longint'(acc_bus.CONV_ACC_InReady), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_no_output", longint'(acc_bus.CONV_ACC_OutValid), 0);
        end

        // Directed table.
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Streaming with OutReady pattern 1,0,0,1.
        acc_cnt = 0;
        cyc     = 0;
        out0    = n_out;
        while (acc_cnt < 20 && cyc < 200) begin
            acc_bus.CONV_ACC_OutReady = rdy_pat[cyc % 4];
            acc_bus.CONV_ACC_InValid  = 1'b1;
            acc_bus.CONV_ACC_Psum     = rand_psum();
            acc_bus.CONV_ACC_Sel      = 13'($urandom);
            @(negedge clk);
            if (acc_bus.CONV_ACC_InReady) acc_cnt++;
            tick();
            cyc++;
        end
        check("stream_accepts", acc_cnt, 20);
        drain();
        check("stream_outputs", n_out - out0, 20);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            acc_bus.CONV_ACC_InValid  = ($urandom_range(0, 3) != 0);
            acc_bus.CONV_ACC_OutReady = ($urandom_range(0, 2) != 0);
            acc_bus.CONV_ACC_Psum     = rand_psum();
            acc_bus.CONV_ACC_Sel      = 13'($urandom);
            tick();
        end
        drain();

        // Empty mask followed by two more, then reset with all three in flight.
        acc_bus.CONV_ACC_OutReady = 1'b1;
        acc_bus.CONV_ACC_InValid  = 1'b1;
        acc_bus.CONV_ACC_Psum     = rand_psum();
        acc_bus.CONV_ACC_Sel      = 13'h0000;
        tick();
        acc_bus.CONV_ACC_Sel = 13'h0ABC;
        tick();
        acc_bus.CONV_ACC_Sel = 13'h1555;
        tick();
        acc_bus.CONV_ACC_InValid = 1'b0;
        check("midrst_mask_err_set", longint'(acc_bus.CONV_ACC_MaskErr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_output", longint'(acc_bus.CONV_ACC_OutValid), 0);
            check("midrst_mask_err_clr", longint'(acc_bus.CONV_ACC_MaskErr), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
